// File: rtl/balance_cntrl.sv
// balance_cntrl: PID balance loop with steering and torque shaping.
// Optional overspeed flag enabled by BALANCE_CNTRL_OVR_SPD_EN.
module balance_cntrl #(
  parameter int P_COEFF         = 14,
  parameter int D_COEFF         = 20,
  parameter int LOW_TORQUE_BAND = 70,
  parameter int GAIN_MULTIPLIER = 15,
  parameter int MIN_DUTY        = 980,
  parameter int OVR_SPD_THRESH  = 1536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] ptch,
  input  logic [11:0] ld_cell_diff,
  input  logic        en_steer,
  input  logic        rider_off,
  input  logic        pwr_up,
  output logic [10:0] lft_spd,
  output logic        lft_rev,
  output logic [10:0] rght_spd,
  output logic        rght_rev,
  output logic        ovr_spd
);

  localparam logic [15:0] LP_BAND = 16'(LOW_TORQUE_BAND);
  localparam logic signed [15:0] LP_MIN = 16'(MIN_DUTY);
  localparam logic [15:0] LP_OVR = 16'(OVR_SPD_THRESH);

  logic signed [9:0]  w_err;
  logic signed [14:0] w_pterm;
  logic signed [17:0] r_integ;
  logic signed [17:0] w_isum;
  logic               w_iovf;
  logic signed [11:0] w_iterm;
  logic signed [9:0]  r_prev1;
  logic signed [9:0]  r_prev2;
  logic signed [9:0]  w_ddiff;
  logic signed [6:0]  w_dsat;
  logic signed [12:0] w_dterm;
  logic signed [15:0] w_pid;
  logic signed [15:0] w_steer;
  logic signed [15:0] w_lt;
  logic signed [15:0] w_rt;
  logic signed [15:0] w_lsh;
  logic signed [15:0] w_rsh;
  logic [15:0]        w_labs;
  logic [15:0]        w_rabs;
  logic               w_ovr_raw;
  logic               w_unused;

  // Clamp the raw pitch into 10-bit signed range
  always_comb begin
    w_err = ptch[9:0];
    if (ptch[15] && !(&ptch[14:9]))
      w_err = 10'sh200;
    else if (!ptch[15] && (|ptch[14:9]))
      w_err = 10'sh1FF;
  end

  assign w_pterm = 15'(32'(w_err) * P_COEFF);

  assign w_isum  = r_integ + 18'(w_err);
  assign w_iovf  = (r_integ[17] == w_err[9]) &&
                   (w_isum[17] != r_integ[17]);
  assign w_iterm = r_integ[17:6];

  // Integrator: clear on rider off / power down, hold on overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_integ <= '0;
    else if (rider_off || !pwr_up)
      r_integ <= '0;
    else if (vld && !w_iovf)
      r_integ <= w_isum;
  end

  // Two-deep pitch history for the derivative
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev1 <= '0;
      r_prev2 <= '0;
    end else if (!pwr_up) begin
      r_prev1 <= '0;
      r_prev2 <= '0;
    end else if (vld) begin
      r_prev2 <= r_prev1;
      r_prev1 <= w_err;
    end
  end

  assign w_ddiff = w_err - r_prev2;

  // Clamp the derivative difference to 7-bit signed
  always_comb begin
    w_dsat = w_ddiff[6:0];
    if (w_ddiff[9] && !(&w_ddiff[8:6]))
      w_dsat = 7'sh40;
    else if (!w_ddiff[9] && (|w_ddiff[8:6]))
      w_dsat = 7'sh3F;
  end

  assign w_dterm = 13'(32'(w_dsat) * D_COEFF);

  assign w_pid = 16'(w_pterm) + 16'(w_iterm) + 16'(w_dterm);

  assign w_steer = 16'($signed(ld_cell_diff[11:3]));
  assign w_lt    = en_steer ? w_pid - w_steer : w_pid;
  assign w_rt    = en_steer ? w_pid + w_steer : w_pid;

  function automatic logic [15:0] f_abs(
    input logic signed [15:0] s
  );
    f_abs = s[15] ? 16'(-s) : 16'(s);
  endfunction

  function automatic logic signed [15:0] f_shape(
    input logic signed [15:0] t
  );
    if (f_abs(t) >= LP_BAND)
      f_shape = t[15] ? t - LP_MIN : t + LP_MIN;
    else
      f_shape = 16'(32'(t) * GAIN_MULTIPLIER);
  endfunction

  assign w_lsh  = f_shape(w_lt);
  assign w_rsh  = f_shape(w_rt);
  assign w_labs = f_abs(w_lsh);
  assign w_rabs = f_abs(w_rsh);

  // Magnitude saturation and power-down gating
  always_comb begin
    lft_spd  = (|w_labs[15:11]) ? 11'h7FF : w_labs[10:0];
    rght_spd = (|w_rabs[15:11]) ? 11'h7FF : w_rabs[10:0];
    lft_rev  = w_lsh[15];
    rght_rev = w_rsh[15];
    if (!pwr_up) begin
      lft_spd  = '0;
      rght_spd = '0;
      lft_rev  = 1'b0;
      rght_rev = 1'b0;
    end
  end

  assign w_ovr_raw = (w_labs > LP_OVR) || (w_rabs > LP_OVR);

`ifdef BALANCE_CNTRL_OVR_SPD_EN
  assign ovr_spd  = pwr_up & w_ovr_raw;
  assign w_unused = ^ld_cell_diff[2:0];
`else
  assign ovr_spd  = 1'b0;
  assign w_unused = ^{ld_cell_diff[2:0], w_ovr_raw};
`endif

endmodule

// File: tb/tb_balance_cntrl.sv
// tb_balance_cntrl: directed steps, expected outputs from an
// integer reference model queued per cycle plus fixed checkpoints.
module tb_balance_cntrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [15:0] ptch;
  logic [11:0] ld_cell_diff;
  logic        en_steer;
  logic        rider_off;
  logic        pwr_up;
  logic [10:0] lft_spd;
  logic        lft_rev;
  logic [10:0] rght_spd;
  logic        rght_rev;
  logic        ovr_spd;

  typedef struct packed {
    logic [10:0] ls;
    logic        lr;
    logic [10:0] rs;
    logic        rr;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int m_int = 0;
  int m_p1  = 0;
  int m_p2  = 0;

  balance_cntrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .ptch         (ptch),
    .ld_cell_diff (ld_cell_diff),
    .en_steer     (en_steer),
    .rider_off    (rider_off),
    .pwr_up       (pwr_up),
    .lft_spd      (lft_spd),
    .lft_rev      (lft_rev),
    .rght_spd     (rght_spd),
    .rght_rev     (rght_rev),
    .ovr_spd      (ovr_spd)
  );

  always #5 clk = ~clk;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int perr();
    return clamp(int'($signed(ptch)), -512, 511);
  endfunction

  function automatic void side(
    input  int          t,
    output logic [10:0] s,
    output logic        r,
    output logic        o
  );
    int sh;
    int a;
    int at;
    at = (t < 0) ? -t : t;
    if (at >= 70) sh = (t >= 0) ? t + 980 : t - 980;
    else          sh = t * 15;
    a = (sh < 0) ? -sh : sh;
    s = (a > 2047) ? 11'd2047 : 11'(a);
    r = (sh < 0);
    o = (a > 1536);
  endfunction

  function automatic exp_t model();
    exp_t x;
    int e, pt, it, df, d, pid, st, lt, rt;
    logic lo, ro;
    e  = perr();
    pt = e * 14;
    it = m_int >>> 6;
    df = e - m_p2;
    if (df > 511)  df = df - 1024;
    if (df < -512) df = df + 1024;
    d   = clamp(df, -64, 63) * 20;
    pid = pt + it + d;
    st  = int'($signed(ld_cell_diff)) >>> 3;
    lt  = en_steer ? pid - st : pid;
    rt  = en_steer ? pid + st : pid;
    side(lt, x.ls, x.lr, lo);
    side(rt, x.rs, x.rr, ro);
`ifdef BALANCE_CNTRL_OVR_SPD_EN
    x.ov = lo | ro;
`else
    x.ov = 1'b0;
`endif
    if (!pwr_up) x = '0;
    return x;
  endfunction

  function automatic void model_edge();
    int n;
    int e;
    e = perr();
    if (!pwr_up || rider_off) begin
      m_int = 0;
    end else if (vld) begin
      n = m_int + e;
      if (n >= -131072 && n <= 131071) m_int = n;
    end
    if (!pwr_up) begin
      m_p1 = 0;
      m_p2 = 0;
    end else if (vld) begin
      m_p2 = m_p1;
      m_p1 = e;
    end
  endfunction

  task automatic chk(
    input string       tag,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    exp_t x;
    #1;
    q.push_back(model());
    @(negedge clk);
    x = q.pop_front();
    chk("lft_spd", 16'(lft_spd), 16'(x.ls));
    chk("lft_rev", 16'(lft_rev), 16'(x.lr));
    chk("rght_spd", 16'(rght_spd), 16'(x.rs));
    chk("rght_rev", 16'(rght_rev), 16'(x.rr));
    chk("ovr_spd", 16'(ovr_spd), 16'(x.ov));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_hist();
    pwr_up = 1'b0;
    vld    = 1'b0;
    tick();
    pwr_up = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    vld          = 1'b0;
    ptch         = '0;
    ld_cell_diff = '0;
    en_steer     = 1'b0;
    rider_off    = 1'b0;
    pwr_up       = 1'b1;
    #2;
    chk("rst_lft", 16'(lft_spd), 16'd0);
    chk("rst_rght", 16'(rght_spd), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    ptch = 16'd2;
    #1;
    chk("band_p_l", 16'(lft_spd), 16'd1020);
    chk("band_p_r", 16'(rght_spd), 16'd1020);
    chk("band_p_rev", 16'(lft_rev), 16'd0);
    vld = 1'b1;
    tick();

    pwr_up = 1'b0;
    #1;
    chk("pwr_off_l", 16'(lft_spd), 16'd0);
    chk("pwr_off_r", 16'(rght_spd), 16'd0);
    clear_hist();

    ptch = 16'hFFFE;
    #1;
    chk("band_n_l", 16'(lft_spd), 16'd1020);
    chk("band_n_rev", 16'(rght_rev), 16'd1);
    vld = 1'b1;
    tick();

    clear_hist();
    ptch = 16'd6;
    #1;
    chk("out_band", 16'(lft_spd), 16'd1184);
    ld_cell_diff = 12'd150;
    en_steer     = 1'b1;
    #1;
    chk("steer_l", 16'(lft_spd), 16'd1166);
    chk("steer_r", 16'(rght_spd), 16'd1202);
    vld = 1'b1;
    repeat (3) tick();
    en_steer     = 1'b0;
    ld_cell_diff = '0;

    clear_hist();
    ptch = 16'd2;
    vld  = 1'b1;
    repeat (70) tick();
    vld = 1'b0;
    #1;
    chk("integ_acc", 16'(lft_spd), 16'd450);
    ptch = 16'hFFF7;
    vld  = 1'b1;
    repeat (64) tick();
    vld = 1'b0;
    #1;
    chk("integ_neg", 16'(lft_spd), 16'd1113);
    chk("integ_neg_rev", 16'(lft_rev), 16'd1);
    ptch      = '0;
    rider_off = 1'b1;
    vld       = 1'b1;
    tick();
    rider_off = 1'b0;
    vld       = 1'b0;
    #1;
    chk("rider_off", 16'(lft_spd), 16'd1160);

    clear_hist();
    ptch = 16'd2;
    repeat (128) begin
      vld = ~vld;
      tick();
    end
    vld = 1'b0;
    #1;
    chk("vld_qual", 16'(rght_spd), 16'd450);

    clear_hist();
    ptch = 16'h01FF;
    vld  = 1'b1;
    repeat (300) tick();
    ptch = '0;
    repeat (2) tick();
    vld = 1'b0;
    #1;
    chk("sat_pos", 16'(lft_spd), 16'h7FF);
    chk("sat_pos_rev", 16'(lft_rev), 16'd0);

    clear_hist();
    ptch = 16'hFE01;
    vld  = 1'b1;
    repeat (300) tick();
    ptch = '0;
    repeat (2) tick();
    vld = 1'b0;
    #1;
    chk("sat_neg", 16'(rght_spd), 16'h7FF);
    chk("sat_neg_rev", 16'(rght_rev), 16'd1);

    clear_hist();
    vld  = 1'b1;
    ptch = 16'h7000;
    repeat (3) tick();
    ptch = 16'h8000;
    repeat (3) tick();
    en_steer     = 1'b1;
    ld_cell_diff = 12'h800;
    repeat (2) tick();
    ld_cell_diff = 12'h7FF;
    ptch         = 16'd3;
    repeat (2) tick();
    en_steer     = 1'b0;
    ld_cell_diff = '0;

    ptch = 16'd5;
    repeat (5) tick();
    rider_off = 1'b1;
    vld       = 1'b0;
    tick();
    rider_off = 1'b0;
    repeat (2) tick();

    ptch = 16'h0100;
    vld  = 1'b1;
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    ptch  = '0;
    vld   = 1'b0;
    #1;
    chk("rst_mid_l", 16'(lft_spd), 16'd0);
    chk("rst_mid_r", 16'(rght_spd), 16'd0);
    m_int = 0;
    m_p1  = 0;
    m_p2  = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
